// File: rtl/peripheral_opexec_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_opexec_pkg
// Shared types and constants for the operand execution stage.
//   op_e       : 3-bit opcode encoding (ADD..REM)
//   state_e    : control FSM states (IDLE, EXEC, ITER, DONE)
//   md_mode_e  : iterative unit mode (multiply or divide)
//   WIDTH_DEF  : default operand/result width
//   CNT_W      : iteration counter width for WIDTH_DEF
//   cnt_width  : counter width for an arbitrary WIDTH (must hold the value WIDTH)
// -----------------------------------------------------------------------------
package peripheral_opexec_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_DIV = 3'b110,
        OP_REM = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    // The counter is loaded with WIDTH itself, hence one bit more than log2.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/peripheral_opexec_muldiv.sv
// -----------------------------------------------------------------------------
// peripheral_opexec_muldiv
// Iterative shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator ({acc_hi, acc_lo}) and one step counter.
//
// Configuration macro: PERIPHERAL_OPEXEC_REM_EN
//   When defined, the remainder output port is present.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture op_a/op_b/mode, clear accumulator, counter <= WIDTH
//   step        : perform one iteration, counter decrements
//   mode        : MD_MUL or MD_DIV, sampled on load
//   op_a, op_b  : multiplicand/dividend and multiplier/divisor
//   product     : full product after the current step (combinational)
//   quotient    : quotient after the current step (combinational)
//   remainder   : remainder after the current step (REM build only)
//   last        : the current step is the final one (counter == 1)
// -----------------------------------------------------------------------------
module peripheral_opexec_muldiv
    import peripheral_opexec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  md_mode_e             mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic                 last
`ifdef PERIPHERAL_OPEXEC_REM_EN
    ,
    output logic [WIDTH-1:0]     remainder
`endif
);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;
    logic [CW-1:0]    count;
    md_mode_e         mode_q;

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Next-step values for both modes. For MUL, acc_lo holds the remaining
    // multiplier bits and the product shifts in from the top. For DIV, acc_lo
    // holds the dividend bits shifting out and quotient bits shifting in, and
    // acc_hi is the partial remainder (always < divisor, so the shifted value
    // fits in WIDTH+1 bits and the successful difference fits in WIDTH bits).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + ({1'b0, operand} & {(WIDTH+1){acc_lo[0]}});
        mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, operand});
        div_trial = div_shift[WIDTH-1:0] - operand;
        rem_next  = div_ok ? div_trial : div_shift[WIDTH-1:0];
        quo_next  = {acc_lo[WIDTH-2:0], div_ok};
    end

    assign product  = mul_next;
    assign quotient = quo_next;
    assign last     = (count == CW'(1));
`ifdef PERIPHERAL_OPEXEC_REM_EN
    assign remainder = rem_next;
`endif

    // Accumulator, operand and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            count   <= '0;
            mode_q  <= MD_MUL;
        end else if (load) begin
            acc_hi  <= '0;
            acc_lo  <= (mode == MD_MUL) ? op_b : op_a;
            operand <= (mode == MD_MUL) ? op_a : op_b;
            count   <= CW'(WIDTH);
            mode_q  <= mode;
        end else if (step) begin
            if (mode_q == MD_MUL) begin
                acc_hi <= mul_next[2*WIDTH-1:WIDTH];
                acc_lo <= mul_next[WIDTH-1:0];
            end else begin
                acc_hi <= rem_next;
                acc_lo <= quo_next;
            end
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/peripheral_opexec.sv
// -----------------------------------------------------------------------------
// peripheral_opexec
// Execution stage behind the operand-collection peripheral. Accepts two
// operands and an opcode on start, runs single-cycle ALU ops or an iterative
// multiply/divide, and presents a held result with status flags.
//
// Configuration macro: PERIPHERAL_OPEXEC_REM_EN
//   Defined   : opcode 111 is REM (remainder of the iterative divide).
//   Undefined : opcode 111 is an illegal opcode.
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   dataA, dataB  : operands (dividend/multiplicand, divisor/multiplier)
//   opcode        : operation select, sampled together with start
//   start         : request, accepted only in IDLE (level-sensitive)
//   busy          : high from accept until the DONE->IDLE edge
//   done          : one-cycle pulse when dataR/flags are updated
//   dataR         : result, held until the next result update
//   flag_zero     : dataR == 0
//   flag_carry    : ADD carry-out / SUB borrow
//   flag_ovf      : MUL upper half of full product nonzero
//   flag_divzero  : DIV/REM with dataB == 0
//   flag_illegal  : unsupported opcode accepted
// -----------------------------------------------------------------------------
module peripheral_opexec
    import peripheral_opexec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [2:0]       opcode,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataR,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_divzero,
    output logic             flag_illegal
);

    state_e           state;
    op_e              op_reg;
    op_e              op_in;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic             need_iter;
    logic             md_load;
    logic             md_step;
    logic             md_last;
    md_mode_e         md_mode;
    logic [2*WIDTH-1:0] md_product;
    logic [WIDTH-1:0] md_quotient;
`ifdef PERIPHERAL_OPEXEC_REM_EN
    logic [WIDTH-1:0] md_remainder;
`endif

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] exec_r;
    logic             exec_carry;
    logic             exec_divzero;
    logic             exec_illegal;
    logic [WIDTH-1:0] iter_r;
    logic             iter_ovf;

    assign op_in = op_e'(opcode);

    // Decide at accept time whether the request goes through the iterative
    // unit. A zero divisor short-circuits to the one-cycle EXEC path.
    always_comb begin
        need_iter = 1'b0;
        case (op_in)
            OP_MUL:  need_iter = 1'b1;
            OP_DIV:  need_iter = (dataB != '0);
`ifdef PERIPHERAL_OPEXEC_REM_EN
            OP_REM:  need_iter = (dataB != '0);
`endif
            default: need_iter = 1'b0;
        endcase
    end

    assign md_load = (state == IDLE) && start && need_iter;
    assign md_step = (state == ITER);
    assign md_mode = (op_in == OP_MUL) ? MD_MUL : MD_DIV;

    peripheral_opexec_muldiv #(
        .WIDTH (WIDTH),
        .CW    (cnt_width(WIDTH))
    ) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .load      (md_load),
        .step      (md_step),
        .mode      (md_mode),
        .op_a      (dataA),
        .op_b      (dataB),
        .product   (md_product),
        .quotient  (md_quotient),
        .last      (md_last)
`ifdef PERIPHERAL_OPEXEC_REM_EN
        ,
        .remainder (md_remainder)
`endif
    );

    // Single-cycle result path, evaluated from the latched operands while in
    // EXEC. DIV/REM only reach here with a zero divisor; MUL never does.
    always_comb begin
        sum          = {1'b0, a_reg} + {1'b0, b_reg};
        exec_r       = '0;
        exec_carry   = 1'b0;
        exec_divzero = 1'b0;
        exec_illegal = 1'b0;
        case (op_reg)
            OP_ADD: begin
                exec_r     = sum[WIDTH-1:0];
                exec_carry = sum[WIDTH];
            end
            OP_SUB: begin
                exec_r     = a_reg - b_reg;
                exec_carry = (a_reg < b_reg);
            end
            OP_AND: exec_r = a_reg & b_reg;
            OP_OR:  exec_r = a_reg | b_reg;
            OP_XOR: exec_r = a_reg ^ b_reg;
            OP_DIV: begin
                exec_r       = '1;
                exec_divzero = 1'b1;
            end
            OP_REM: begin
`ifdef PERIPHERAL_OPEXEC_REM_EN
                exec_r       = a_reg;
                exec_divzero = 1'b1;
`else
                exec_r       = '0;
                exec_illegal = 1'b1;
`endif
            end
            default: exec_r = '0;
        endcase
    end

    // Result selection for the final iteration step.
    always_comb begin
        iter_r   = md_quotient;
        iter_ovf = 1'b0;
        case (op_reg)
            OP_MUL: begin
                iter_r   = md_product[WIDTH-1:0];
                iter_ovf = |md_product[2*WIDTH-1:WIDTH];
            end
`ifdef PERIPHERAL_OPEXEC_REM_EN
            OP_REM: iter_r = md_remainder;
`endif
            default: iter_r = md_quotient;
        endcase
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_reg       <= OP_ADD;
            a_reg        <= '0;
            b_reg        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dataR        <= '0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            flag_ovf     <= 1'b0;
            flag_divzero <= 1'b0;
            flag_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= dataA;
                        b_reg  <= dataB;
                        op_reg <= op_in;
                        busy   <= 1'b1;
                        state  <= need_iter ? ITER : EXEC;
                    end
                end
                EXEC: begin
                    dataR        <= exec_r;
                    flag_zero    <= (exec_r == '0);
                    flag_carry   <= exec_carry;
                    flag_ovf     <= 1'b0;
                    flag_divzero <= exec_divzero;
                    flag_illegal <= exec_illegal;
                    done         <= 1'b1;
                    state        <= DONE;
                end
                ITER: begin
                    if (md_last) begin
                        dataR        <= iter_r;
                        flag_zero    <= (iter_r == '0);
                        flag_carry   <= 1'b0;
                        flag_ovf     <= iter_ovf;
                        flag_divzero <= 1'b0;
                        flag_illegal <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/peripheral_opexec.md
Name: peripheral_opexec

Overview:
Execution stage directly downstream of the operand-collection peripheral. Consumes the assembled 32-bit operands dataA/dataB plus a 3-bit opcode on a start request. Produces the 32-bit result dataR that the operand peripheral reads back byte-wise for display.
Single-cycle logic/arithmetic ops; iterative shift-add multiply and restoring divide; start/busy/done handshake.

Parameters:
WIDTH, 32, operand/result width; iteration count for MUL/DIV equals WIDTH.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
dataA  input  WIDTH  operand A (dividend / multiplicand)
dataB  input  WIDTH  operand B (divisor / multiplier)
opcode  input  3  operation select, sampled with start
start  input  1  request; accepted only in IDLE
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when dataR/flags become valid
dataR  output  WIDTH  result, held until next accepted start
flag_zero  output  1  dataR == 0
flag_carry  output  1  ADD carry-out / SUB borrow; 0 otherwise
flag_ovf  output  1  MUL: upper WIDTH bits of full product nonzero; 0 otherwise
flag_divzero  output  1  DIV/REM with dataB == 0
flag_illegal  output  1  unsupported opcode accepted

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values: all outputs 0; state IDLE; internal operand, accumulator and counter registers 0.
- Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 MUL (low WIDTH bits), 110 DIV (unsigned quotient), 111 REM (see optional feature).
- States: IDLE, EXEC, ITER, DONE.
- IDLE: at edge k with start=1, latch dataA, dataB and opcode.
  - Single-cycle opcode -> EXEC.
  - MUL -> ITER.
  - DIV/REM with B != 0 -> ITER.
  - DIV/REM with B == 0 -> EXEC.
  - Illegal opcode -> EXEC.
  - Iteration counter loads WIDTH.
- EXEC: result and flags registered at edge k+1; -> DONE.
- ITER: one multiply or divide step per edge; counter decrements.
  - When the counter reaches 0 (edge k+WIDTH), register result and flags; -> DONE.
- DONE: done=1 for exactly this cycle; -> IDLE on the next edge.
- busy is high from edge k until the DONE->IDLE edge.
- Latency, start accept to done high:
  - 1 cycle for single-cycle ops, div-by-zero and illegal opcodes.
  - WIDTH cycles for MUL/DIV/REM.
- start is level-sensitive in IDLE. If it is held high through DONE, a new operation is accepted in the IDLE cycle that follows. start in EXEC/ITER/DONE is ignored; operand changes during busy are ignored.
- dataR and flags change only at the result-register edge. They hold their values across the following IDLE period.
- Arithmetic:
  - ADD: {carry, R} = A + B (WIDTH+1 bits).
  - SUB: borrow = (A < B) unsigned.
  - MUL: shift-add over a 2*WIDTH accumulator; ovf = |product[2W-1:W].
  - DIV: restoring, 1 quotient bit per step, unsigned; remainder kept internally.
- Divide by zero: R = all ones, flag_divzero=1, flag_zero=0.
- Illegal opcode: R = 0, flag_illegal=1, flag_zero=1.
- Reset mid-operation (any state) aborts immediately: IDLE, outputs cleared, no done pulse.

Optional Feature:
- Macro: PERIPHERAL_OPEXEC_REM_EN.
- Defined: opcode 111 = REM. Uses the DIV iteration path and returns the final remainder. flag_divzero on B==0 with R = dataA.
- Undefined: opcode 111 is illegal (R=0, flag_illegal=1, 1-cycle latency). The remainder register may be optimised away.

Decomposition:
- Package peripheral_opexec_pkg holds:
  - op_e enum (OP_ADD..OP_REM);
  - state_e enum (IDLE, EXEC, ITER, DONE);
  - WIDTH default constant;
  - counter width constant = $clog2(WIDTH)+1.
- One sub-module, peripheral_opexec_muldiv:
  - owns the iterative accumulator, shift registers and counter;
  - ports: load, step, mode (MUL/DIV), operands, product/quotient/remainder;
  - top keeps the FSM, single-cycle ALU, flags and output registers.

Test Plan:
- ADD A=0xFFFFFFFF, B=0x00000001 -> done 1 cycle after accept, dataR=0x00000000, flag_zero=1, flag_carry=1.
- SUB A=5, B=7 -> dataR=0xFFFFFFFE, flag_carry=1. XOR A=0xF0F0F0F0, B=0xFFFF0000 -> 0x0F0FF0F0.
- MUL A=0x00012345, B=0x00000100 -> done exactly 32 cycles after accept, dataR=0x01234500, flag_ovf=0.
- MUL A=0x00010000, B=0x00010000 -> dataR=0, flag_ovf=1, flag_zero=1.
- DIV A=100, B=7 -> dataR=14 after 32 cycles.
- REM A=100, B=7 -> dataR=2 with the macro defined; flag_illegal=1 and dataR=0 after 1 cycle without it.
- DIV A=0x1234, B=0 -> 1-cycle latency, dataR=0xFFFFFFFF, flag_divzero=1.
- Start MUL, pulse start with ADD at cycle 5 (ignored), then assert reset at cycle 10:
  - immediately busy=0, dataR=0, all flags 0;
  - no done pulse;
  - a subsequent ADD 2+3 -> 5.
